// File: rtl/sonar_pkg.sv
// Shared state encoding, default timing constants and sizing helpers for the
// multi-channel ultrasonic ranging block.
package sonar_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIGGER   = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TRIG_PD = 1000;    // 10 us at 100 MHz
    localparam int DEF_TIMEOUT = 60000;
    localparam int DEF_HOLDOFF = 100000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sonar_sync.sv
// Two-flop synchronizer bringing one asynchronous echo line into the clk domain.
module sonar_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/sonar_array.sv
// Round-robin ultrasonic sensor scanner: triggers each channel in turn, times
// its echo pulse, and publishes one result per channel with a timeout flag.
module sonar_array
    import sonar_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TRIG_PD = DEF_TRIG_PD,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int HOLDOFF = DEF_HOLDOFF,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_trig,
    input  logic              cont,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trig,
    output logic              idle,
    output logic [CNT_W-1:0]  count_echo,
    output logic [CH_W-1:0]   ch_id,
    output logic              valid,
    output logic              timeout
);

    // One shared timer covers the trigger pulse, the echo window and the holdoff.
    localparam int TMR_W = $clog2(max3(TRIG_PD, TIMEOUT, HOLDOFF) + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_PD - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   count;
    logic [NUM_CH-1:0]  echo_s;
    logic               echo_cur;
    logic               trig_done;
    logic               tmo_hit;
    logic               hold_done;
    logic               last_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        sonar_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (echo[i]),
            .q   (echo_s[i])
        );
    end

    assign echo_cur  = echo_s[ch];
    assign trig_done = (timer == TRIG_LAST);
    assign tmo_hit   = (timer == TMO_LAST);
    assign hold_done = (timer == HOLD_LAST);
    assign last_ch   = (ch == CH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (send_trig || cont) begin
                    state_nxt = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (trig_done) begin
                    state_nxt = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (tmo_hit) begin
                    state_nxt = S_HOLDOFF;
                end else if (echo_cur) begin
                    state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (tmo_hit || !echo_cur) begin
                    state_nxt = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (hold_done) begin
                    state_nxt = (!last_ch || cont) ? S_TRIGGER : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        idle = (state == S_IDLE);
        trig = '0;
        if (state == S_TRIGGER) begin
            trig[ch] = 1'b1;
        end
    end

    // The timer keeps running through S_MEASURE so the timeout bounds the whole ping.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            ch         <= '0;
            count      <= '0;
            count_echo <= '0;
            ch_id      <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    ch    <= '0;
                end
                S_TRIGGER: begin
                    timer <= trig_done ? '0 : timer + TMR_W'(1);
                end
                S_WAIT_RISE: begin
                    timer <= timer + TMR_W'(1);
                    if (tmo_hit) begin
                        timer      <= '0;
                        count_echo <= '1;
                        ch_id      <= ch;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                    end else if (echo_cur) begin
                        // The cycle that revealed the rise is the first high cycle.
                        count <= CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (tmo_hit) begin
                        timer      <= '0;
                        count_echo <= '1;
                        ch_id      <= ch;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                    end else if (!echo_cur) begin
                        timer      <= '0;
                        count_echo <= count;
                        ch_id      <= ch;
                        timeout    <= 1'b0;
                        valid      <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        count <= count + CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (hold_done) begin
                        timer <= '0;
                        ch    <= last_ch ? '0 : ch + CH_W'(1);
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
